// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_unit: PC generation, 1-cycle imem read, 2-entry decode skid FIFO.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic [31:0] ALUResultE,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic [31:0] IMemRdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  input  logic        ReadyD
);

  localparam logic [1:0] c_src_target = 2'b01;
  localparam logic [1:0] c_src_alu    = 2'b10;

  logic [31:0] r_pcf;
  logic [31:0] r_inflight_pc;
  logic        r_inflight;
  logic [31:0] r_fifo_instr [2];
  logic [31:0] r_fifo_pc    [2];
  logic        r_head;
  logic [1:0]  r_count;

  logic        w_redirect;
  logic [31:0] w_redirect_pc;
  logic        w_valid;
  logic        w_pop;
  logic        w_push;
  logic        w_req;
  logic        w_tail;
  logic [2:0]  w_pending;

  assign w_redirect    = (PCSrcE == c_src_target) || (PCSrcE == c_src_alu);
  assign w_redirect_pc = (PCSrcE == c_src_target) ? PCTargetE : {ALUResultE[31:1], 1'b0};

  assign w_valid = !rst && !w_redirect && (r_count != 2'd0);
  assign w_pop   = w_valid && ReadyD;
  assign w_push  = r_inflight && !w_redirect;
  assign w_tail  = r_head ^ r_count[0];

  // Credit counts queued entries plus the outstanding read, so a response always has a slot.
  assign w_pending = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_req     = !rst && !w_redirect && (w_pending < 3'd2);

  assign IMemReq  = w_req;
  assign IMemAddr = r_pcf;

  assign ValidD   = w_valid;
  assign InstrD   = w_valid ? r_fifo_instr[r_head] : NOP_INSTR;
  assign PCD      = w_valid ? r_fifo_pc[r_head] : 32'h0000_0000;
  assign PCPlus4D = PCD + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcf      <= RESET_PC;
      r_inflight <= 1'b0;
      r_head     <= 1'b0;
      r_count    <= 2'd0;
    end else if (w_redirect) begin
      r_pcf      <= w_redirect_pc;
      r_inflight <= 1'b0;
      r_head     <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      r_inflight <= w_req;
      if (w_req) begin
        r_pcf         <= r_pcf + 32'd4;
        r_inflight_pc <= r_pcf;
      end
      if (w_push) begin
        r_fifo_instr[w_tail] <= IMemRdata;
        r_fifo_pc[w_tail]    <= r_inflight_pc;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && (r_count == 2'd2) && !w_pop));

endmodule
`default_nettype wire
